// File: rtl/poly_tone_pkg.sv
// Shared types, note-code limits and the octave-4 increment table for poly_tone_synth.
// Increments are computed at elaboration from centi-hertz frequencies, the clock rate and the accumulator width.
package poly_tone_pkg;

    localparam int OCT_TOP  = 4;
    localparam int SEMI_MAX = 12;

    typedef struct packed {
        logic [2:0] oct;
        logic [3:0] semi;
    } note_t;

    // C6..B6 in centi-hertz (A6 = 1760 Hz), indexed directly by the semitone code 1..12.
    localparam int unsigned INC4_FREQ_CHZ [16] = '{
        0,      104650, 110873, 117466, 124451, 131851, 139691, 147998,
        156798, 166122, 176000, 186466, 197553, 0,      0,      0
    };

    function automatic longint unsigned calc_inc(input longint unsigned freq_chz,
                                                 input longint unsigned clk_hz,
                                                 input int              acc_w);
        longint unsigned den;
        den = clk_hz * 64'd100;
        return ((freq_chz << acc_w) + den / 64'd2) / den;
    endfunction

    function automatic logic note_valid(input note_t n);
        return (n.semi != 4'd0) && (n.semi <= 4'(SEMI_MAX)) && (n.oct <= 3'(OCT_TOP));
    endfunction

endpackage

// File: rtl/poly_tone_synth_voice.sv
// tone_voice: one phase-accumulator voice with increment/volume registers.
// With POLY_TONE_ENV_EN defined, amp ramps toward its target on env_tick and rests keep a release tail.
module tone_voice
    import poly_tone_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int VOL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             playing,
`ifdef POLY_TONE_ENV_EN
    input  logic             env_tick,
`endif
    input  logic             wr_en,
    input  logic             wr_ok,
    input  logic [ACC_W-1:0] wr_inc,
    input  logic [VOL_W-1:0] wr_vol,
    output logic             sq,
    output logic             active,
    output logic [VOL_W-1:0] amp
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [VOL_W-1:0] vol;
    logic             note_on;

`ifdef POLY_TONE_ENV_EN
    logic [VOL_W-1:0] amp_q;
    logic [VOL_W-1:0] target;
    logic             silent;

    assign target = note_on ? vol : '0;
    assign silent = !note_on && (amp_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            inc     <= '0;
            vol     <= '0;
            note_on <= 1'b0;
            amp_q   <= '0;
        end else begin
            if (env_tick) begin
                if (amp_q < target)      amp_q <= amp_q + VOL_W'(1);
                else if (amp_q > target) amp_q <= amp_q - VOL_W'(1);
            end
            // A rest keeps the old pitch running until the release tail has decayed.
            if (silent) inc <= '0;
            if (wr_en) begin
                vol     <= wr_vol;
                note_on <= wr_ok;
                if (wr_ok) inc <= wr_inc;
            end
            if (!playing || silent || (wr_en && wr_ok && !note_on)) acc <= '0;
            else                                                    acc <= acc + inc;
        end
    end

    assign amp    = amp_q;
    assign active = playing && ((note_on && (vol != '0)) || (amp_q != '0));
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            inc     <= '0;
            vol     <= '0;
            note_on <= 1'b0;
        end else begin
            if (wr_en) begin
                vol     <= wr_vol;
                note_on <= wr_ok;
                inc     <= wr_ok ? wr_inc : '0;
            end
            // Valid-to-valid pitch changes keep the phase; anything touching a rest restarts at 0.
            if (!playing || (wr_en && (!wr_ok || !note_on))) acc <= '0;
            else                                             acc <= acc + inc;
        end
    end

    assign amp    = note_on ? vol : '0;
    assign active = playing && note_on && (vol != '0);
`endif

    assign sq = playing && acc[ACC_W-1];

endmodule

// File: rtl/poly_tone_synth.sv
// poly_tone_synth: config handshake, increment LUT stage, N_CH voices, mixer and 1-bit PWM output.
// Define POLY_TONE_ENV_EN to enable per-voice amplitude envelopes (adds the ENV_DIV parameter).
module poly_tone_synth
    import poly_tone_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int VOL_W  = 2,
    parameter int ACC_W  = 32,
    parameter int CLK_HZ = 50000000
`ifdef POLY_TONE_ENV_EN
    , parameter int ENV_DIV = 4096
`endif
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     playing,
    input  logic                                     cfg_valid,
    output logic                                     cfg_ready,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [7:0]                               cfg_note,
    input  logic [VOL_W-1:0]                         cfg_vol,
    output logic [N_CH-1:0]                          ch_sq,
    output logic [N_CH-1:0]                          ch_active,
    output logic                                     audio_out
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SUM_W = VOL_W + $clog2(N_CH);

    logic [ACC_W-1:0] inc4 [16];
    for (genvar j = 0; j < 16; j++) begin : g_inc4
        localparam logic [ACC_W-1:0] INC =
            ACC_W'(calc_inc(64'(INC4_FREQ_CHZ[j]), 64'(CLK_HZ), ACC_W));
        assign inc4[j] = INC;
    end

    logic unused_note_msb;
    assign unused_note_msb = cfg_note[7];

    logic             s1_vld, s2_vld, s2_ok;
    logic [CH_W-1:0]  s1_ch, s2_ch;
    note_t            s1_note;
    logic [VOL_W-1:0] s1_vol, s2_vol;
    logic [ACC_W-1:0] s2_base;
    logic [2:0]       s2_oct;

    // NOTE: every sequential register uses <= so all stages read pre-edge values and the pipeline shifts cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_ready <= 1'b0;
            s1_vld    <= 1'b0;
            s1_ch     <= '0;
            s1_note   <= '0;
            s1_vol    <= '0;
            s2_vld    <= 1'b0;
            s2_ch     <= '0;
            s2_ok     <= 1'b0;
            s2_base   <= '0;
            s2_oct    <= '0;
            s2_vol    <= '0;
        end else begin
            cfg_ready <= !(cfg_valid && cfg_ready);
            s1_vld    <= cfg_valid && cfg_ready;
            if (cfg_valid && cfg_ready) begin
                s1_ch   <= cfg_ch;
                s1_note <= note_t'(cfg_note[6:0]);
                s1_vol  <= cfg_vol;
            end
            s2_vld  <= s1_vld;
            s2_ch   <= s1_ch;
            s2_ok   <= note_valid(s1_note);
            s2_base <= inc4[s1_note.semi];
            s2_oct  <= s1_note.oct;
            s2_vol  <= s1_vol;
        end
    end

    logic [ACC_W-1:0] wr_inc;
    logic [N_CH-1:0]  wr_en;
    logic [VOL_W-1:0] amp [N_CH];

    assign wr_inc = s2_ok ? (s2_base >> (3'(OCT_TOP) - s2_oct)) : '0;

`ifdef POLY_TONE_ENV_EN
    localparam int ENV_CW = $clog2(ENV_DIV);
    logic [ENV_CW-1:0] env_cnt;
    logic              env_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            env_cnt  <= '0;
            env_tick <= 1'b0;
        end else begin
            env_tick <= (env_cnt == ENV_CW'(ENV_DIV - 1));
            env_cnt  <= (env_cnt == ENV_CW'(ENV_DIV - 1)) ? '0 : env_cnt + ENV_CW'(1);
        end
    end
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_voice
        assign wr_en[i] = s2_vld && (s2_ch == CH_W'(i));
        tone_voice #(
            .ACC_W (ACC_W),
            .VOL_W (VOL_W)
        ) u_voice (
            .clk      (clk),
            .reset    (reset),
            .playing  (playing),
`ifdef POLY_TONE_ENV_EN
            .env_tick (env_tick),
`endif
            .wr_en    (wr_en[i]),
            .wr_ok    (s2_ok),
            .wr_inc   (wr_inc),
            .wr_vol   (s2_vol),
            .sq       (ch_sq[i]),
            .active   (ch_active[i]),
            .amp      (amp[i])
        );
    end

    logic [SUM_W-1:0] sum, sum_q, pwm_cnt;

    // NOTE: sum gets a default before the loop so the combinational block never infers a latch.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sq[i]) sum = sum + SUM_W'(amp[i]);
        end
    end

    // The duty cycle only changes at frame wrap so a frame never mixes two levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt   <= '0;
            sum_q     <= '0;
            audio_out <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + SUM_W'(1);
            if (&pwm_cnt) sum_q <= sum;
            audio_out <= playing && (pwm_cnt < sum_q);
        end
    end

endmodule

// File: tb/tb_poly_tone_synth.sv
// Directed bench for poly_tone_synth (N_CH=4, VOL_W=2, ACC_W=32, CLK_HZ=50 MHz, default build).
// Expected timings are hand-derived from the note frequencies and the 2^32 accumulator.
module tb_poly_tone_synth;

    logic       clk = 1'b0;
    logic       reset;
    logic       playing;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_note;
    logic [1:0] cfg_vol;
    logic [3:0] ch_sq;
    logic [3:0] ch_active;
    logic       audio_out;

    int checks   = 0;
    int failures = 0;

    poly_tone_synth #(
        .N_CH   (4),
        .VOL_W  (2),
        .ACC_W  (32),
        .CLK_HZ (50000000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .playing   (playing),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_note  (cfg_note),
        .cfg_vol   (cfg_vol),
        .ch_sq     (ch_sq),
        .ch_active (ch_active),
        .audio_out (audio_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp,
                         input longint tol = 0);
        longint diff;
        checks++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] note, input logic [1:0] vol);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_note  = note;
        cfg_vol   = vol;
        while (!cfg_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("cfg_ready timeout", 0, 1);
        tick();
        cfg_valid = 1'b0;
    endtask

    // Write, then let the two pipeline stages land it in the voice.
    task automatic write_settle(input logic [1:0] ch, input logic [7:0] note, input logic [1:0] vol);
        cfg_write(ch, note, vol);
        tick();
        tick();
    endtask

    task automatic wait_sq(input int idx, input logic level, input int budget, output int n);
        n = 0;
        while (ch_sq[idx] !== level && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic count_audio(output int hi);
        hi = 0;
        repeat (16) begin
            if (audio_out) hi++;
            tick();
        end
    endtask

    initial begin
        int n_rise, n_fall, n_hi;

        reset     = 1'b1;
        playing   = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_note  = '0;
        cfg_vol   = '0;

        // Reset state
        #1;
        check("rst cfg_ready", cfg_ready, 0);
        check("rst ch_sq", ch_sq, 0);
        check("rst ch_active", ch_active, 0);
        check("rst audio_out", audio_out, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("ready before first clk", cfg_ready, 0);
        tick();
        check("ready after first clk", cfg_ready, 1);

        // 1: ch0 A4 (0x2A): inc = 151183>>2 = 37795
        playing = 1'b1;
        write_settle(2'd0, 8'h2A, 2'd3);
        check("t1 ch_active", ch_active, 4'b0001);
        repeat (4000) tick();
        check("t1 sq low half", ch_sq[0], 0);

        // 2: switch to A6 (0x4A, inc 151183) keeping phase.
        // acc at switch = 4003*37795 = 151293385; (2^31-acc)/151183 -> 13204 clocks (14205 if acc were reset)
        write_settle(2'd0, 8'h4A, 2'd3);
        wait_sq(0, 1'b1, 20000, n_rise);
        check("t2 first rise keeps phase", n_rise, 13204, 20);
        wait_sq(0, 1'b0, 20000, n_fall);
        wait_sq(0, 1'b1, 20000, n_rise);
        check("t2 period A6", n_fall + n_rise, 28409, 28);

        // 4: rest codes and back-to-back handshake, ch0 currently high
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_note  = 8'h20;
        cfg_vol   = 2'd3;
        check("t4 ready[0]", cfg_ready, 1);
        tick();
        check("t4 ready[1]", cfg_ready, 0);
        cfg_note = 8'h5D;
        tick();
        check("t4 ready[2]", cfg_ready, 1);
        tick();
        check("t4 ready[3]", cfg_ready, 0);
        cfg_valid = 1'b0;
        check("t4 0x20 sq", ch_sq[0], 0);
        check("t4 0x20 active", ch_active[0], 0);
        write_settle(2'd0, 8'h4B, 2'd2);
        check("t4 valid active", ch_active[0], 1);
        write_settle(2'd0, 8'h5D, 2'd2);
        check("t4 0x5D active", ch_active[0], 0);
        write_settle(2'd0, 8'h4B, 2'd2);
        write_settle(2'd0, 8'h0F, 2'd2);
        check("t4 0x0F active", ch_active[0], 0);

        // 3: all voices B6 (0x4C, half period ~12655 clocks), mixer duty per 16-clock frame
        cfg_write(2'd0, 8'h4C, 2'd3);
        cfg_write(2'd1, 8'h4C, 2'd1);
        cfg_write(2'd2, 8'h4C, 2'd0);
        cfg_write(2'd3, 8'h4C, 2'd0);
        repeat (12700) tick();
        check("t3 all squares high", ch_sq, 4'b1111);
        check("t3 active vol0 off", ch_active, 4'b0011);
        repeat (40) tick();
        count_audio(n_hi);
        check("t3 duty 3+1", n_hi, 4);
        cfg_write(2'd1, 8'h4C, 2'd3);
        cfg_write(2'd2, 8'h4C, 2'd3);
        write_settle(2'd3, 8'h4C, 2'd3);
        repeat (40) tick();
        check("t3 squares still high", ch_sq, 4'b1111);
        check("t3 active all", ch_active, 4'b1111);
        count_audio(n_hi);
        check("t3 duty 4x3", n_hi, 12);

        // 5: pause mid-tone, write while paused, resume from phase 0
        playing = 1'b0;
        tick();
        check("t5 audio off next clk", audio_out, 0);
        check("t5 sq off", ch_sq, 0);
        check("t5 active off", ch_active, 0);
        write_settle(2'd0, 8'h4A, 2'd2);
        check("t5 paused active", ch_active, 0);
        playing = 1'b1;
        tick();
        check("t5 resume active", ch_active, 4'b1111);
        check("t5 resume sq phase0", ch_sq, 0);
        repeat (1000) tick();
        check("t5 still low half", ch_sq, 0);
        count_audio(n_hi);
        check("t5 audio silent low half", n_hi, 0);

        // 6: reset pulse between accept and store
        cfg_write(2'd1, 8'h4C, 2'd3);
        reset = 1'b1;
        #1;
        check("t6 async active", ch_active, 0);
        check("t6 async sq", ch_sq, 0);
        check("t6 async audio", audio_out, 0);
        check("t6 async ready", cfg_ready, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("t6 ready back", cfg_ready, 1);
        repeat (4) tick();
        check("t6 write lost", ch_active, 0);
        check("t6 sq idle", ch_sq, 0);
        repeat (40) tick();
        check("t6 audio idle", audio_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
